// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller: stalls the CPU, copies XFER_LEN bytes from {page,8'h00}
// to the OAM data port, then returns the bus to the CPU.
module oam_dma_ctrl #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR    = 16'h2004,
  parameter int                    XFER_LEN     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  output logic                  cpu_rdy,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  dma_busy,
  output logic                  dma_done
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;

  localparam logic [8:0] LAST = 9'(XFER_LEN - 1);

  state_t                  state, state_nxt;
  logic                    parity;
  logic [DATA_WIDTH-1:0]   page;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [8:0]              count;
  logic                    trig;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic                    unused_latch;

  assign trig     = cpu_we && (cpu_addr == TRIGGER_ADDR);
  assign accept   = trig && (state == IDLE || state == DONE);
  // Only the low byte of count forms the source offset, so the page never carries.
  assign src_addr = ADDR_WIDTH'({page, count[7:0]});
  assign cpu_rdata = bus_rdata;
  // Byte latch exists purely for waveform inspection.
  assign unused_latch = ^data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= '0;
      count  <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      if (accept) begin
        page  <= cpu_wdata;
        count <= '0;
      end
      if (state == WRITE) begin
        data_q <= bus_rdata;
        count  <= count + 9'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_rdy   = 1'b1;
    dma_busy  = 1'b0;
    dma_done  = 1'b0;
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_we    = cpu_we;
    case (state)
      IDLE: if (trig) state_nxt = HALT;
      HALT, ALIGN: begin
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        bus_addr  = TRIGGER_ADDR;
        bus_wdata = '0;
        bus_we    = 1'b0;
        // An odd-parity halt needs one extra cycle to line up with the read slot.
        if (state == HALT && parity) state_nxt = ALIGN;
        else                         state_nxt = READ;
      end
      READ: begin
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        bus_addr  = src_addr;
        bus_wdata = '0;
        bus_we    = 1'b0;
        state_nxt = WRITE;
      end
      WRITE: begin
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        bus_addr  = DEST_ADDR;
        bus_wdata = bus_rdata;
        bus_we    = 1'b1;
        state_nxt = (count == LAST) ? DONE : READ;
      end
      DONE: begin
        dma_done  = 1'b1;
        state_nxt = trig ? HALT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: ROM model on the bus, scoreboard queues for
// DMA read addresses and written bytes, stall-length and done-pulse monitors.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic        dma_busy;
  logic        dma_done;

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .dma_busy(dma_busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // Read-only memory: data appears the cycle after the address.
  logic [7:0] mem [0:65535];
  always @(posedge clk) bus_rdata <= mem[bus_addr];

  // Get/put parity as seen by the controller: cleared by reset, toggles each clock.
  logic par = 1'b0;
  always @(posedge clk) par <= reset ? 1'b0 : ~par;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  wr_q [$];
  logic [15:0] rd_q [$];
  int          wr_cnt = 0, done_cnt = 0, run = 0, last_stall = 0;
  bit          saw_zero = 1'b0;
  logic [15:0] last_rd = '0;

  always @(negedge clk) begin
    if (!reset) begin
      check("bus_we_known", 32'($isunknown(bus_we)), 32'd0);
      if (dma_done) done_cnt++;
      if (!cpu_rdy) run++;
      else if (run != 0) begin
        last_stall = run;
        run = 0;
      end
      if (dma_busy && bus_we) begin
        wr_cnt++;
        check("wr_addr", 32'(bus_addr), 32'h2004);
        check("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) check("wr_data", 32'(bus_wdata), 32'(wr_q.pop_front()));
      end else if (dma_busy && bus_addr != 16'h4014) begin
        last_rd = bus_addr;
        if (bus_addr == 16'h0000) saw_zero = 1'b1;
        check("rd_q_nonempty", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check("rd_addr", 32'(bus_addr), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_par(bit want);
    do step(); while (par !== want);
  endtask

  // Drives a trigger write in the current cycle and queues the expected transfer.
  task automatic trigger(logic [7:0] pg, output int exp_stall);
    logic [15:0] a;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    exp_stall = par ? 513 : 514;
    for (int i = 0; i < 256; i++) begin
      a = {pg, 8'(i)};
      rd_q.push_back(a);
      wr_q.push_back(mem[a]);
    end
    @(negedge clk);
    check("trig_pass_addr", 32'(bus_addr), 32'h4014);
    check("trig_pass_we", 32'(bus_we), 32'd1);
    check("trig_pass_data", 32'(bus_wdata), 32'(pg));
    step();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0010;
    @(negedge clk);
    check("halt_busy", 32'(dma_busy), 32'd1);
    check("halt_rdy", 32'(cpu_rdy), 32'd0);
  endtask

  task automatic wait_done(string tag, int exp_stall);
    int d0 = done_cnt;
    for (int k = 0; k < 1200 && done_cnt == d0; k++) @(posedge clk);
    #1;
    check({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_stall"}, 32'(last_stall), 32'(exp_stall));
    check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    repeat (3) step();
    check({tag, "_one_pulse"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle_rdy"}, 32'(cpu_rdy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int es, es2, d0, w0;
    logic [15:0] a16;
    for (int a = 0; a < 65536; a++) begin
      a16 = 16'(a);
      mem[a] = a16[7:0] ^ 8'h5A ^ a16[15:8] ^ 8'h02;
    end
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'h00;
    repeat (3) step();
    @(negedge clk);
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_done", 32'(dma_done), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    step();
    reset = 1'b0;

    // CPU-owned bus mirrors the CPU pins.
    for (int i = 0; i < 10; i++) begin
      step();
      cpu_addr = 16'h0010; cpu_we = i[0]; cpu_wdata = 8'($urandom);
      @(negedge clk);
      check("idle_addr", 32'(bus_addr), 32'h0010);
      check("idle_we", 32'(bus_we), 32'(i[0]));
      check("idle_wdata", 32'(bus_wdata), 32'(cpu_wdata));
      check("idle_rdata", 32'(cpu_rdata), 32'(bus_rdata));
      check("idle_rdy", 32'(cpu_rdy), 32'd1);
      check("idle_busy", 32'(dma_busy), 32'd0);
    end
    cpu_we = 1'b0;

    // HALT on even parity (trigger cycle parity 1) then on odd parity.
    go_par(1'b1); trigger(8'h02, es); wait_done("even", 513);
    go_par(1'b0); trigger(8'h02, es); wait_done("odd", 514);

    // Top page: source must stop at 16'hFFFF without wrapping to 16'h0000.
    saw_zero = 1'b0;
    step(); trigger(8'hFF, es); wait_done("pgff", es);
    check("pgff_last_rd", 32'(last_rd), 32'hFFFF);
    check("pgff_no_zero", 32'(saw_zero), 32'd0);

    // Reset mid-transfer after write #100.
    d0 = done_cnt; w0 = wr_cnt;
    step(); trigger(8'h02, es);
    for (int k = 0; k < 400 && wr_cnt < w0 + 100; k++) step();
    check("abort_at_100", 32'(wr_cnt - w0), 32'd100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_rdy", 32'(cpu_rdy), 32'd1);
    check("abort_busy", 32'(dma_busy), 32'd0);
    check("abort_done", 32'(dma_done), 32'd0);
    wr_q.delete(); rd_q.delete();
    repeat (10) step();
    check("abort_no_pulse", 32'(done_cnt - d0), 32'd0);
    step(); trigger(8'h03, es); wait_done("pg03", es);

    // Back-to-back: second trigger lands in the DONE cycle of the first.
    step(); trigger(8'h02, es);
    for (int k = 0; k < 1200 && dma_done !== 1'b1; k++) step();
    check("b2b_in_done", 32'(dma_done), 32'd1);
    check("b2b_wr_empty", 32'(wr_q.size()), 32'd0);
    d0 = done_cnt;
    trigger(8'h04, es2);
    check("b2b_first_stall", 32'(last_stall), 32'(es));
    check("b2b_first_done", 32'(done_cnt - d0), 32'd1);
    check("b2b_queued", 32'(wr_q.size()), 32'd256);
    wait_done("b2b_second", es2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
